// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot decoder / scan sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: none; the block has no flow control.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest output vector the helper can build; callers size-cast down to NUM_OUT.
  localparam int ONEHOT_MAX = 256;

  // One-hot of idx; all-zero when idx falls outside 0..num_out-1.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int idx, input int num_out);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < ONEHOT_MAX; i++) begin
      v[i] = (i == idx) && (i < num_out);
    end
    return v;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell timer: up-counter 0..dwell_q with terminal count; restarts and re-samples dwell on tc.
// Latency: tc_o is combinational from the registered count; clr/reload take effect next edge.
// Backpressure: none; run_i simply gates counting.
// Ports: clk_i, rst_ni (async low); clr_i zeroes the count keeping dwell_q;
//        reload_i zeroes the count and samples dwell_i; run_i advances; tc_o = (cnt == dwell_q).
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               reload_i,
  input  logic               run_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               tc_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  assign tc_o = (cnt_q == dwell_q);

  always_comb begin
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (reload_i) begin
      cnt_d   = '0;
      dwell_d = dwell_i;
    end else if (run_i) begin
      if (tc_o) begin
        // End of a dwell period: start the next one with a fresh period length.
        cnt_d   = '0;
        dwell_d = dwell_i;
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/decoder_scan_nx.sv
// Registered one-hot decoder with automatic scan sequencing (LED digit / keypad row strobes).
// Latency: one cycle from load/mode/en to out_o; every output is a register.
// Backpressure: none; load_i is a single-cycle strobe that is always accepted or flagged by err_o.
// Ports: en_i (0 blanks), mode_i (0 direct, 1 scan), load_i/sel_i (new index), dwell_i
//        (scan period - 1); out_o one-hot, idx_o active index, busy_o, wrap_o, err_o pulses.
module decoder_scan_nx
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int NUM_OUT = 16,
  parameter int DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               mode_i,
  input  logic               load_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [NUM_OUT-1:0] out_o,
  output logic [SEL_W-1:0]   idx_o,
  output logic               busy_o,
  output logic               wrap_o,
  output logic               err_o
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               busy_q, wrap_q, wrap_d, err_q, err_d;
  logic               t_clr, t_reload, t_run, t_tc;
  logic               load_ok, at_last;

  assign load_ok = load_i && (int'(sel_i) < NUM_OUT);
  assign at_last = (idx_q == SEL_W'(NUM_OUT - 1));

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (t_clr),
    .reload_i (t_reload),
    .run_i    (t_run),
    .dwell_i  (dwell_i),
    .tc_o     (t_tc)
  );

  // Priority: en, then mode change, then load, then scan step.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    err_d    = load_i && !load_ok;
    t_clr    = 1'b0;
    t_reload = 1'b0;
    t_run    = 1'b0;

    if (!en_i) begin
      state_d = ST_IDLE;
      t_clr   = 1'b1;
      // Only a block already parked in IDLE may be pre-loaded while disabled.
      if (state_q == ST_IDLE && load_ok) idx_d = sel_i;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DIRECT: begin
          if (mode_i == MODE_SCAN) begin
            state_d  = ST_SCAN;
            t_reload = 1'b1;
          end else begin
            state_d = ST_DIRECT;
            t_clr   = 1'b1;
          end
          if (load_ok) idx_d = sel_i;
        end
        ST_SCAN: begin
          if (mode_i == MODE_DIRECT) begin
            state_d = ST_DIRECT;
            t_clr   = 1'b1;
            if (load_ok) idx_d = sel_i;
          end else if (load_ok) begin
            // A load restarts the dwell period and suppresses any same-cycle step.
            idx_d = sel_i;
            t_clr = 1'b1;
          end else begin
            t_run = 1'b1;
            if (t_tc) begin
              idx_d  = at_last ? '0 : idx_q + SEL_W'(1);
              wrap_d = at_last;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          t_clr   = 1'b1;
        end
      endcase
    end

    out_d = (state_d == ST_IDLE) ? '0 : NUM_OUT'(onehot(int'(idx_d), NUM_OUT));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      busy_q  <= (state_d != ST_IDLE);
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out_o  = out_q;
  assign idx_o  = idx_q;
  assign busy_o = busy_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;

endmodule

// File: doc/decoder_scan_nx.md
Name: decoder_scan_nx

Overview:
- Parametrised registered one-hot decoder and row/digit scan sequencer. Next generation of the 4x16 combinational decoder.
- Direct mode: decodes a loaded select into a registered one-hot output.
- Scan mode: steps the active output automatically through 0..NUM_OUT-1 with a programmable dwell time.
- Drives LED/7-seg digit enables and keypad row strobes from a single clock domain.

Parameters:
SEL_W, 4, select/index width
NUM_OUT, 16, number of outputs; legal range 2..2**SEL_W, need not be a power of two
DWELL_W, 8, dwell counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; 0 forces all outputs low
mode  input  1  0 = direct decode, 1 = auto scan
load  input  1  single-cycle strobe: take sel as the new index
sel  input  SEL_W  index to load
dwell  input  DWELL_W  scan step period minus one, in clk cycles
out  output  NUM_OUT  registered one-hot (or all-zero) output
idx  output  SEL_W  current active index
busy  output  1  high when state is not IDLE
wrap  output  1  one-cycle pulse when scan steps from NUM_OUT-1 to 0
err  output  1  one-cycle pulse when load has sel >= NUM_OUT

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, out=0, idx=0, cnt=0, dwell_q=0, busy=0, wrap=0, err=0. Reset mid-scan clears everything immediately, without waiting for a clock edge.
- All outputs are registered. out always equals (state==IDLE ? 0 : 1<<idx) as of the same edge.
- States: IDLE, DIRECT, SCAN.
  - Any state with en=0: go to IDLE next edge; out=0; idx holds its value. cnt is cleared.
  - IDLE with en=1, mode=0: go to DIRECT; out=1<<idx on that edge.
  - IDLE with en=1, mode=1: go to SCAN; out=1<<idx; cnt=0; dwell_q=dwell.
  - DIRECT with en=1, mode=1: go to SCAN from the current idx. cnt=0; dwell_q=dwell.
  - SCAN with en=1, mode=0: go to DIRECT and hold the current idx.
- Direct mode:
  - load=1 with sel<NUM_OUT: idx=sel and out=1<<sel on the next edge. Latency is one cycle.
  - No load: hold idx and out.
- Scan mode:
  - cnt counts 0..dwell_q. When cnt==dwell_q: idx = (idx==NUM_OUT-1) ? 0 : idx+1, cnt=0, and dwell_q re-samples dwell.
  - Each index is therefore active for exactly dwell_q+1 cycles. dwell=0 steps every cycle.
  - wrap=1 for exactly the one cycle in which idx is registered as 0 following NUM_OUT-1.
- Load handling:
  - load in any state (including IDLE): if sel>=NUM_OUT, the load is ignored, err=1 for one cycle, and idx/out/cnt are unchanged.
  - A valid load in IDLE updates idx only; out stays 0.
  - A valid load in SCAN sets idx=sel and cnt=0, and takes priority over a same-cycle step. No wrap pulse is produced by a load.
- Simultaneous events:
  - Priority order is en=0, then mode change, then load, then step.
  - load on the same edge as a mode change is applied to idx in the new state.
- idx arithmetic is modulo NUM_OUT, not 2**SEL_W.

Decomposition:
- Shared package decoder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_DIRECT=2'd1, ST_SCAN=2'd2
  - MODE_DIRECT/MODE_SCAN constants
  - function onehot(idx, NUM_OUT)
- One natural sub-module: dwell_timer (loadable DWELL_W down/up counter with terminal-count output, clear, and synchronous reload).
- FSM, index register and output register stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-scan, asynchronously, between clock edges -> out=0, idx=0, busy=0, wrap=0 immediately, before the next clk edge.
- Direct sweep: NUM_OUT=16, en=1, mode=0, load sel=0..15 one per cycle -> out=16'h0001<<sel one cycle after each load; err never asserted.
- Scan timing: NUM_OUT=16, dwell=2, mode=1 from idx=0 -> idx changes every 3 cycles. wrap pulses once 48 cycles after entry, as idx goes 15->0.
- Load in scan: dwell=4, load sel=9 on a cycle where cnt==4 -> idx=9 and cnt=0 (the load beats the step); idx=10 five cycles later; no wrap pulse.
- Non-power-of-two: NUM_OUT=10, scan with dwell=0 -> idx cycles 0..9 with wrap every 10 cycles. Load sel=12 -> err=1 for one cycle; idx and out unchanged.
- Enable drop and mode switch: en=0 during SCAN at idx=5 -> out=0 next edge. en=1 with mode=0 -> out=1<<5 next edge. mode=1 -> scan resumes from 5 with cnt=0.
